mem_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data-access requester (ME) of the 5-stage MIPS pipeline.
- Serialises requests with one outstanding transaction at a time.
- Chooses the requester fairly and produces the i_stall / d_stall signals consumed by the hazard unit (i_stallF, d_stallM).

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one SRAM-like memory port between the instruction-fetch (IF) and
// data-access (ME) requesters of the 5-stage MIPS pipeline. One transaction
// is outstanding at a time. Ties go to data unless data had the previous
// grant, so neither requester waits behind more than one foreign transaction.
//
// Optional build macro: ARB_TIMEOUT_EN
//   Adds a bus_err output and an 8-bit WAIT-state counter. After TIMEOUT
//   WAIT cycles with no mem_data_ok, the granted requester is completed with
//   rdata = 0 and bus_err pulses for one cycle. Without the macro, the block
//   waits indefinitely for mem_data_ok.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   inst_req/inst_addr       IF request (held until inst_data_ok)
//   inst_addr_ok/inst_data_ok/inst_rdata   IF handshake pulses and read data
//   data_req/data_wr/data_wstrb/data_addr/data_wdata   ME request
//   data_addr_ok/data_data_ok/data_rdata   ME handshake pulses and read data
//   mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata   memory request channel
//   mem_addr_ok/mem_data_ok/mem_rdata      memory handshakes and read data
//   bus_err                  (ARB_TIMEOUT_EN only) one-cycle timeout pulse
//   i_stall/d_stall          stall requests to the hazard unit
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic        bus_err,
`endif
  output logic        i_stall,
  output logic        d_stall
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;
  localparam int unsigned CntW  = 8;

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if ((TIMEOUT == 0) || (TIMEOUT > 255)) begin : gBadTimeout
    $error("mem_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } arbState_e;

  arbState_e         state;
  logic              lastGrant;   // 0 = inst had the last grant, 1 = data
  logic [AddrW-1:0]  holdAddr;
  logic              holdWr;
  logic [StrbW-1:0]  holdWstrb;
  logic [DataW-1:0]  holdWdata;

  logic inAddr;
  logic inWait;
  logic grantData;
  logic grantInst;
  logic waitDone;
  logic rdValid;

  assign inAddr = (state == I_ADDR) || (state == D_ADDR);
  assign inWait = (state == I_WAIT) || (state == D_WAIT);

  // Data wins a tie unless it also won the previous one.
  assign grantData = data_req & (~inst_req | ~lastGrant);
  assign grantInst = inst_req & ~grantData;

  // Read data is forwarded only on a genuine memory response.
  assign rdValid = inWait & mem_data_ok;

`ifdef ARB_TIMEOUT_EN
  // Counter holds 0 in the first WAIT cycle, so the timeout fires in the
  // TIMEOUT-th WAIT cycle. A real response in that cycle takes precedence.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] waitCnt;
  logic            timeoutHit;

  assign timeoutHit = inWait & ~mem_data_ok & (waitCnt == TimeoutLast);
  assign waitDone   = inWait & (mem_data_ok | timeoutHit);
  assign bus_err    = timeoutHit;
`else
  assign waitDone   = inWait & mem_data_ok;
`endif

  // Memory request channel is driven straight from the holding registers.
  assign mem_req   = inAddr;
  assign mem_wr    = holdWr;
  assign mem_wstrb = holdWstrb;
  assign mem_addr  = holdAddr;
  assign mem_wdata = holdWdata;

  // Requester handshakes follow the memory handshakes in the same cycle.
  assign inst_addr_ok = (state == I_ADDR) & mem_addr_ok;
  assign data_addr_ok = (state == D_ADDR) & mem_addr_ok;
  assign inst_data_ok = (state == I_WAIT) & waitDone;
  assign data_data_ok = (state == D_WAIT) & waitDone;
  assign inst_rdata   = ((state == I_WAIT) && rdValid) ? mem_rdata : '0;
  assign data_rdata   = ((state == D_WAIT) && rdValid) ? mem_rdata : '0;

  assign i_stall = inst_req & ~inst_data_ok;
  assign d_stall = data_req & ~data_data_ok;

  // Arbitration FSM with grant capture into the holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b0;
      holdAddr  <= '0;
      holdWr    <= 1'b0;
      holdWstrb <= '0;
      holdWdata <= '0;
`ifdef ARB_TIMEOUT_EN
      waitCnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grantData) begin
            state     <= D_ADDR;
            lastGrant <= 1'b1;
            holdAddr  <= data_addr;
            holdWr    <= data_wr;
            holdWstrb <= data_wstrb;
            holdWdata <= data_wdata;
          end else if (grantInst) begin
            state     <= I_ADDR;
            lastGrant <= 1'b0;
            holdAddr  <= inst_addr;
            holdWr    <= 1'b0;
            holdWstrb <= '0;
            holdWdata <= '0;
          end
        end

        I_ADDR, D_ADDR: begin
          if (mem_addr_ok) begin
            state <= (state == I_ADDR) ? I_WAIT : D_WAIT;
`ifdef ARB_TIMEOUT_EN
            waitCnt <= '0;
`endif
          end
        end

        I_WAIT, D_WAIT: begin
          if (waitDone) begin
            state <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            waitCnt <= waitCnt + CntW'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    bit          isData;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } expTxn_t;

  expTxn_t sb[$];
  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        i_stall;
  logic        d_stall;
`ifdef ARB_TIMEOUT_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
`ifdef ARB_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .i_stall(i_stall), .d_stall(d_stall)
  );

  // Inputs change 2 time units after a rising edge; outputs are sampled 1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic void pushTxn(input bit isData, input logic [31:0] addr, input logic wr,
                                  input logic [3:0] wstrb, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
    expTxn_t e;
    e.isData = isData;
    e.addr   = addr;
    e.wr     = isData ? wr : 1'b0;
    e.wstrb  = isData ? wstrb : 4'h0;
    e.wdata  = wdata;
    e.rdata  = rdata;
    sb.push_back(e);
  endfunction

  // Memory model: accepts the next request, checks it against the scoreboard
  // head, then answers with the given address/data latencies.
  task automatic memServe(input int addrLat, input int dataLat, input bit dropReq,
                          input bit scramble);
    expTxn_t e;
    int n;
    n = 0;
    #1;
    while (mem_req !== 1'b1 && n < 20) begin
      cyc(); #1; n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL memReqWait mem_req=%b required 1", mem_req);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sbEmpty unexpected request addr=%h", mem_addr);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (mem_addr !== e.addr || mem_wr !== e.wr || mem_wstrb !== e.wstrb ||
        (e.isData && mem_wdata !== e.wdata)) begin
      errors++;
      $display("FAIL memFields got addr=%h wr=%b wstrb=%h wdata=%h required addr=%h wr=%b wstrb=%h wdata=%h",
               mem_addr, mem_wr, mem_wstrb, mem_wdata, e.addr, e.wr, e.wstrb, e.wdata);
    end
    if (scramble) begin
      inst_addr  = ~inst_addr;
      data_addr  = ~data_addr;
      data_wdata = ~data_wdata;
      data_wstrb = ~data_wstrb;
      data_wr    = ~data_wr;
    end
    for (int k = 0; k < addrLat; k++) begin
      cyc(); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_wr !== e.wr || mem_wstrb !== e.wstrb ||
          (e.isData && mem_wdata !== e.wdata) || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL memHold req=%b addr=%h wr=%b wstrb=%h wdata=%h required addr=%h wr=%b wstrb=%h wdata=%h",
                 mem_req, mem_addr, mem_wr, mem_wstrb, mem_wdata, e.addr, e.wr, e.wstrb, e.wdata);
      end
    end
    mem_addr_ok = 1'b1;
    #1;
    checks++;
    if (inst_addr_ok !== !e.isData || data_addr_ok !== e.isData) begin
      errors++;
      $display("FAIL addrOk inst=%b data=%b required inst=%b data=%b",
               inst_addr_ok, data_addr_ok, !e.isData, e.isData);
    end
    cyc();
    mem_addr_ok = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL waitReq mem_req=%b required 0", mem_req);
    end
    for (int k = 1; k < dataLat; k++) begin
      checks++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0 ||
          data_rdata !== 32'h0 || i_stall !== inst_req || d_stall !== data_req) begin
        errors++;
        $display("FAIL earlyData iok=%b dok=%b ird=%h drd=%h is=%b ds=%b required 0 0 0 0 %b %b",
                 inst_data_ok, data_data_ok, inst_rdata, data_rdata, i_stall, d_stall,
                 inst_req, data_req);
      end
      cyc(); #1;
    end
    mem_data_ok = 1'b1;
    mem_rdata   = e.rdata;
    #1;
    checks++;
    if (e.isData) begin
      if (data_data_ok !== 1'b1 || data_rdata !== e.rdata || inst_data_ok !== 1'b0 ||
          inst_rdata !== 32'h0 || d_stall !== 1'b0 || i_stall !== inst_req) begin
        errors++;
        $display("FAIL dataDone dok=%b drd=%h iok=%b ird=%h ds=%b is=%b required 1 %h 0 0 0 %b",
                 data_data_ok, data_rdata, inst_data_ok, inst_rdata, d_stall, i_stall,
                 e.rdata, inst_req);
      end
    end else begin
      if (inst_data_ok !== 1'b1 || inst_rdata !== e.rdata || data_data_ok !== 1'b0 ||
          data_rdata !== 32'h0 || i_stall !== 1'b0 || d_stall !== data_req) begin
        errors++;
        $display("FAIL instDone iok=%b ird=%h dok=%b drd=%h is=%b ds=%b required 1 %h 0 0 0 %b",
                 inst_data_ok, inst_rdata, data_data_ok, data_rdata, i_stall, d_stall,
                 e.rdata, data_req);
      end
    end
    cyc();
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom();
    if (dropReq) begin
      if (e.isData) data_req = 1'b0;
      else          inst_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 ||
        inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0 ||
        data_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wr !== 1'b0 ||
        mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL resetOutputs req=%b addr=%h wr=%b wstrb=%h iok=%b dok=%b required all 0",
               mem_req, mem_addr, mem_wr, mem_wstrb, inst_data_ok, data_data_ok);
    end
    checks++;
    if (i_stall !== 1'b1 || d_stall !== 1'b1) begin
      errors++;
      $display("FAIL resetStallsHigh is=%b ds=%b required 1 1", i_stall, d_stall);
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    checks++;
    if (i_stall !== 1'b0 || d_stall !== 1'b0) begin
      errors++;
      $display("FAIL resetStallsLow is=%b ds=%b required 0 0", i_stall, d_stall);
    end
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 || inst_data_ok !== 1'b0 ||
        data_data_ok !== 1'b0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idleIgnore iao=%b dao=%b iok=%b dok=%b required 0 0 0 0",
               inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
    end
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idleStay mem_req=%b required 0", mem_req);
    end
    cyc();
  endtask

  task automatic test_lone_fetch();
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    pushTxn(1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h3C1D_0000);
    memServe(0, 2, 1'b1, 1'b0);
    #1;
    checks++;
    if (i_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetchAfter is=%b req=%b required 0 0", i_stall, mem_req);
    end
    cyc();
  endtask

  task automatic test_store();
    data_addr  = 32'h8000_1004;
    data_wdata = 32'h0000_BEEF;
    data_wstrb = 4'b0011;
    data_wr    = 1'b1;
    data_req   = 1'b1;
    pushTxn(1'b1, 32'h8000_1004, 1'b1, 4'b0011, 32'h0000_BEEF, 32'hA5A5_0001);
    memServe(3, 1, 1'b1, 1'b1);
    cyc();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    inst_addr = 32'h0040_0000;
    data_addr = 32'h1001_0000; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
    inst_req = 1'b1; data_req = 1'b1;
    cyc();
    rst = 1'b0;
    pushTxn(1'b1, 32'h1001_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0011);
    pushTxn(1'b0, 32'h0040_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0022);
    pushTxn(1'b1, 32'h1001_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0033);
    pushTxn(1'b0, 32'h0040_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0044);
    for (int t = 0; t < 4; t++) memServe(0, 1, 1'b0, 1'b0);
    inst_req = 1'b0; data_req = 1'b0;
    cyc(); #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL contentionEnd mem_req=%b required 0", mem_req);
    end
    cyc();
  endtask

  task automatic test_reset_midop();
    data_addr = 32'h8000_2000; data_wr = 1'b0; data_wstrb = 4'hF; data_req = 1'b1;
    cyc(); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_2000) begin
      errors++;
      $display("FAIL midopAddr req=%b addr=%h required 1 80002000", mem_req, mem_addr);
    end
    mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midopWait mem_req=%b required 0", mem_req);
    end
    cyc();
    rst = 1'b1; data_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL midopReset req=%b addr=%h wstrb=%h dok=%b required 0 0 0 0",
               mem_req, mem_addr, mem_wstrb, data_data_ok);
    end
    cyc();
    rst = 1'b0;
    cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (data_data_ok !== 1'b0 || data_rdata !== 32'h0 || inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL lateResp dok=%b drd=%h iok=%b required 0 0 0", data_data_ok, data_rdata, inst_data_ok);
    end
    cyc();
    mem_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL postResetIdle cycle=%0d mem_req=%b required 0", k, mem_req);
      end
      cyc();
    end
    inst_addr = 32'hBFC0_0380; inst_req = 1'b1;
    pushTxn(1'b0, 32'hBFC0_0380, 1'b0, 4'h0, 32'h0, 32'h4008_6000);
    memServe(1, 1, 1'b1, 1'b0);
    cyc();
  endtask

  task automatic test_stalls();
    inst_addr = 32'h0040_0010; inst_req = 1'b1;
    data_addr = 32'h1001_0040; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
    pushTxn(1'b0, 32'h0040_0010, 1'b0, 4'h0, 32'h0, 32'h2402_0005);
    pushTxn(1'b1, 32'h1001_0040, 1'b0, 4'h0, 32'h0, 32'h0000_0777);
    cyc();
    data_req = 1'b1;
    #1;
    checks++;
    if (d_stall !== 1'b1 || i_stall !== 1'b1) begin
      errors++;
      $display("FAIL stallRaise ds=%b is=%b required 1 1", d_stall, i_stall);
    end
    memServe(0, 3, 1'b1, 1'b0);
    #1;
    checks++;
    if (d_stall !== 1'b1 || i_stall !== 1'b0) begin
      errors++;
      $display("FAIL stallBetween ds=%b is=%b required 1 0", d_stall, i_stall);
    end
    memServe(0, 1, 1'b1, 1'b0);
    #1;
    checks++;
    if (d_stall !== 1'b0) begin
      errors++;
      $display("FAIL stallClear ds=%b required 0", d_stall);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    bit          isData;
    logic [31:0] a, w, r;
    logic [3:0]  s;
    logic        wr;
    for (int t = 0; t < 8; t++) begin
      isData = 1'($urandom_range(0, 1));
      a  = $urandom(); w = $urandom(); r = $urandom();
      s  = 4'($urandom()); wr = 1'($urandom());
      if (isData) begin
        data_addr = a; data_wdata = w; data_wstrb = s; data_wr = wr; data_req = 1'b1;
      end else begin
        inst_addr = a; inst_req = 1'b1;
      end
      pushTxn(isData, a, wr, s, w, r);
      memServe(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'b1, 1'b0);
    end
    cyc();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    data_addr = 32'h8000_3000; data_wr = 1'b0; data_wstrb = 4'h0; data_req = 1'b1;
    cyc(); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL toAddr mem_req=%b required 1", mem_req);
    end
    mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0; mem_rdata = 32'h1234_5678;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if (data_data_ok !== 1'b0 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL toEarly wait=%0d dok=%b err=%b required 0 0", k, data_data_ok, bus_err);
      end
      cyc();
    end
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h0 || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL toFire dok=%b drd=%h err=%b required 1 0 1", data_data_ok, data_rdata, bus_err);
    end
    cyc();
    data_req = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0 || mem_req !== 1'b0 || data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL toAfter err=%b req=%b dok=%b required 0 0 0", bus_err, mem_req, data_data_ok);
    end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hCAFE_F00D;
    cyc();
    test_reset();
    test_lone_fetch();
    test_store();
    test_contention();
    test_reset_midop();
    test_stalls();
    test_back_to_back();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sbLeftover entries=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
